// File: rtl/spi_slave.sv
`default_nettype none
// spi_slave: SPI mode-0 peripheral endpoint oversampled on the system clock,
// MSB-first shifting with a one-word transmit buffer.  Rev 1.0
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       sck_sync;
  logic [2:0]       ss_sync;
  logic [1:0]       mosi_sync;
  logic [1:0]       prime_cnt;
  logic [CW-1:0]    bit_cnt;
  logic             word_done;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             buf_full;

  logic             sck_rise;
  logic             sck_fall;
  logic             ss_fall;
  logic             ss_rise;
  logic             do_load;
  logic [WIDTH-1:0] rx_next;

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign ss_fall  = ~ss_sync[1] & ss_sync[2];
  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign rx_next  = {rx_shift[WIDTH-2:0], mosi_sync[1]};

  assign do_load = ((state == IDLE) && ss_fall) ||
                   ((state == ACTIVE) && !ss_rise && sck_fall && word_done);

  assign miso     = tx_shift[WIDTH-1];
  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~buf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync    <= 3'b000;
      ss_sync     <= 3'b111;
      mosi_sync   <= 2'b00;
      prime_cnt   <= 2'd0;
      state       <= DISARMED;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[1:0], sck};
      ss_sync     <= {ss_sync[1:0], ss};
      mosi_sync   <= {mosi_sync[0], mosi};
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // The ss chain starts out holding its reset value of 1; wait until the
      // real pin level has reached the second stage before trusting it.
      if (prime_cnt != 2'd2) prime_cnt <= prime_cnt + 2'd1;

      case (state)
        DISARMED: begin
          if (prime_cnt == 2'd2 && ss_sync[1]) state <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            state     <= ACTIVE;
            bit_cnt   <= '0;
            word_done <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_done <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                rx_data   <= rx_next;
                rx_valid  <= 1'b1;
                bit_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            if (sck_fall) begin
              if (word_done) word_done <= 1'b0;
              else           tx_shift  <= tx_shift << 1;
            end
          end
        end
        default: state <= DISARMED;
      endcase

      if (do_load) begin
        if (buf_full) begin
          tx_shift <= tx_buf;
          buf_full <= 1'b0;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end

      // A write in the same cycle as an underrunning load lands in the buffer.
      if (tx_valid && !buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// tb_spi_slave: directed SPI master stimulus with a cycle-level reference model.
module tb_spi_slave;

  localparam int HALF   = 6;
  localparam int EV_SSF = 0;
  localparam int EV_SSR = 1;
  localparam int EV_RX  = 2;
  localparam int EV_LD  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_slave #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rx_cnt = 0;
  int   und_cnt = 0;
  bit   trk = 1'b1;
  bit   model_on = 1'b0;

  // Reference model: frame activity, buffer occupancy, last word, strobes.
  bit         m_busy, m_full, m_rxv, m_und;
  logic [7:0] m_buf, m_rx, m_word;
  bit         rst_s, tv_s, old_full;
  logic [7:0] td_s;
  ev_t        cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A pin change driven now is first sampled at the next edge; its effect
  // registers two edges after that.
  task automatic sched(input int kind, input logic [7:0] d);
    ev_t e;
    if (trk) begin
      e.cyc  = cyc + 3;
      e.kind = kind;
      e.d    = d;
      evq.push_back(e);
    end
  endtask

  task automatic model_load(input bit was_full);
    if (was_full) begin
      m_word = m_buf;
      m_full = 1'b0;
    end else begin
      m_word = 8'h00;
      m_und  = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      rst_s = rst;
      tv_s  = tx_valid;
      td_s  = tx_data;
      cyc++;
      #1;
      m_rxv = 1'b0;
      m_und = 1'b0;
      if (rst_s) begin
        m_busy = 1'b0; m_full = 1'b0; m_rx = 8'h00; m_buf = 8'h00; m_word = 8'h00;
        evq.delete();
        model_on = 1'b1;
      end else begin
        old_full = m_full;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          cur = evq.pop_front();
          case (cur.kind)
            EV_SSF: begin m_busy = 1'b1; model_load(old_full); end
            EV_SSR: m_busy = 1'b0;
            EV_RX:  begin m_rxv = 1'b1; m_rx = cur.d; end
            EV_LD:  model_load(old_full);
            default: ;
          endcase
        end
        if (tv_s && !old_full) begin
          m_buf  = td_s;
          m_full = 1'b1;
        end
      end
      if (model_on) begin
        chk("busy",        busy,        m_busy);
        chk("miso_oe",     miso_oe,     m_busy);
        chk("tx_ready",    tx_ready,    !m_full);
        chk("rx_valid",    rx_valid,    m_rxv);
        chk("tx_underrun", tx_underrun, m_und);
        chk("rx_data",     rx_data,     m_rx);
        if (rx_valid === 1'b1)    rx_cnt++;
        if (tx_underrun === 1'b1) und_cnt++;
      end
    end
  end

  task automatic push_tx(input logic [7:0] d);
    bit hs;
    bit done;
    done = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      hs = tx_ready;
      @(negedge clk);
      if (hs) done = 1'b1;
    end
    tx_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic ss_fall_t();
    @(negedge clk);
    ss = 1'b0;
    sched(EV_SSF, 8'h00);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_rise_t();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    sched(EV_SSR, 8'h00);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_word(input logic [7:0] out, output logic [7:0] got, input int nbits);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = out[7-i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      got[7-i] = miso;
      if (i == 7) begin
        sched(EV_RX, out);
        if (trk) chk("miso_word", got, m_word);
      end
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      if (i == 7) sched(EV_LD, 8'h00);
    end
  endtask

  initial begin
    logic [7:0] g, g1, g2;
    int r0, u0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_miso_oe",  miso_oe,  1'b0);
    chk("rst_miso",     miso,     1'b0);
    chk("rst_rx_data",  rx_data,  8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_underrun", tx_underrun, 1'b0);
    repeat (4) @(negedge clk);

    // single byte
    push_tx(8'h5A);
    r0 = rx_cnt;
    ss_fall_t();
    chk("single_ready", tx_ready, 1'b1);
    spi_word(8'hAB, g, 8);
    ss_rise_t();
    chk("single_read",  g, 8'h5A);
    chk("single_rx",    rx_data, 8'hAB);
    chk("single_count", rx_cnt - r0, 1);

    // back-to-back words, feeder keeps the buffer topped up
    push_tx(8'h12);
    r0 = rx_cnt;
    u0 = und_cnt;
    fork
      begin
        ss_fall_t();
        spi_word(8'hC3, g1, 8);
        chk("b2b_rx1", rx_data, 8'hC3);
        spi_word(8'h3C, g2, 8);
        ss_rise_t();
      end
      begin
        push_tx(8'h34);
        push_tx(8'hEE);
      end
    join
    chk("b2b_read1", g1, 8'h12);
    chk("b2b_read2", g2, 8'h34);
    chk("b2b_rx2",   rx_data, 8'h3C);
    chk("b2b_count", rx_cnt - r0, 2);
    chk("b2b_no_underrun", und_cnt - u0, 0);

    // underrun
    u0 = und_cnt;
    ss_fall_t();
    chk("und_pulse", und_cnt - u0, 1);
    spi_word(8'h96, g, 8);
    ss_rise_t();
    chk("und_read", g, 8'h00);
    chk("und_rx",   rx_data, 8'h96);

    // abort after 5 bits
    r0 = rx_cnt;
    ss_fall_t();
    spi_word(8'hF0, g, 5);
    ss_rise_t();
    chk("abort_count", rx_cnt - r0, 0);
    chk("abort_busy",  busy, 1'b0);
    chk("abort_rx",    rx_data, 8'h96);
    ss_fall_t();
    spi_word(8'h81, g, 8);
    ss_rise_t();
    chk("after_abort_rx", rx_data, 8'h81);

    // reset in the middle of a frame
    ss_fall_t();
    spi_word(8'h55, g, 3);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0 = rx_cnt;
    trk = 1'b0;
    spi_word(8'hAA, g, 8);
    chk("midrst_oe",    miso_oe, 1'b0);
    chk("midrst_count", rx_cnt - r0, 0);
    ss_rise_t();
    trk = 1'b1;
    push_tx(8'hA5);
    ss_fall_t();
    spi_word(8'hE7, g, 8);
    ss_rise_t();
    chk("midrst_read", g, 8'hA5);
    chk("midrst_rx",   rx_data, 8'hE7);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 (CPOL=0, CPHA=0) peripheral-side endpoint running on the fabric system clock. It connects the design to an external SPI master. It oversamples the asynchronous `sck`/`ss`/`mosi` pins through synchronizers and shifts words MSB-first in both directions. Toward the fabric it exposes a one-word transmit buffer with a valid/ready handshake and a received-word strobe.

## Interface
- `WIDTH`, default 8: bits per SPI word (≥2).
- `clk`  in  1  system clock (12 MHz nominal).
- `rst`  in  1  synchronous reset, active-high.
- `sck`  in  1  SPI clock from master, asynchronous to `clk`.
- `ss`  in  1  chip select from master, active-low, asynchronous.
- `mosi`  in  1  serial data from master, asynchronous.
- `miso`  out  1  serial data to master (registered).
- `miso_oe`  out  1  output enable for the `miso` pad; high while selected.
- `tx_data`  in  WIDTH  next word to transmit.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmit buffer empty; transfer occurs when `tx_valid && tx_ready`.
- `rx_data`  out  WIDTH  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `tx_underrun`  out  1  one-cycle strobe: a word started with the transmit buffer empty.
- `busy`  out  1  high while a frame is active (synchronized `ss` low and armed).

## Operation
- **Synchronization**
  - `sck`, `ss`, `mosi` each pass through 2 flops.
  - `sck` and `ss` get a third flop for edge detection.
  - Synchronizer reset values: `sck`=0, `ss`=1, `mosi`=0.
- **States**
  - DISARMED (after reset) -> IDLE once synchronized `ss`=1.
  - IDLE -> ACTIVE on synchronized `ss` falling edge.
  - ACTIVE -> IDLE on synchronized `ss` rising edge.
  - Reset while `ss` is low therefore never joins a frame mid-word.
- **Word load** (on `ss` fall, and on the first `sck` falling edge after a completed word while `ss` stays low)
  - Buffer full: `tx_shift` <= buffer, buffer marked empty.
  - Buffer empty: `tx_shift` <= 0 and `tx_underrun` pulses.
- **`sck` rising edge (ACTIVE)**
  - `rx_shift` <= {`rx_shift`[WIDTH-2:0], `mosi`}; bit counter +1.
  - On the WIDTH-th bit: `rx_data` <= assembled word, `rx_valid` pulses, counter <= 0, word-done flag set.
- **`sck` falling edge (ACTIVE)**
  - Word-done set: perform a word load, clear the flag.
  - Otherwise: `tx_shift` <= `tx_shift` << 1.
- **Outputs**
  - `miso` = registered `tx_shift`[WIDTH-1].
  - `miso_oe` = ACTIVE.
- **Transmit buffer**
  - Written only when `tx_valid && tx_ready`.
  - If a word load and a buffer write fall in the same cycle, the load sees the old (empty) state and underruns; the written word stays in the buffer.
  - Buffer contents survive frame boundaries.
- **Abort** (`ss` rises mid-word)
  - Partial word discarded, no `rx_valid`.
  - Counter and word-done flag cleared.
  - A word already moved into `tx_shift` is lost; the buffer is unaffected.
- **Ignored inputs**
  - `sck` edges in IDLE or DISARMED are ignored.
  - `mosi` is ignored outside rising edges.

## Timing
- **Reset values**
  - `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0.
  - State DISARMED, counter 0, buffer empty.
- **Pin-to-action latency**
  - Let edge k be the first `clk` edge sampling the new pin level. The action registers at edge k+2.
  - `rx_valid` and `rx_data` change at k+2 of the last `sck` rise.
  - `miso` changes at k+2 of the `sck` fall.
  - `tx_ready` rises at k+2 of the load event.
- **Master constraints**
  - `sck` high and low phases ≥4 `clk` periods each (≤1.5 MHz at 12 MHz).
  - ≥4 `clk` periods from `ss` low to the first `sck` rise.
  - ≥4 `clk` periods from the last `sck` fall to `ss` high.
  - `ss` high ≥4 `clk` periods between frames.
- **Strobe widths**
  - `rx_valid` and `tx_underrun` are exactly 1 cycle.
  - `rx_valid` occurs once per completed word, including back-to-back words.

## Test plan
- **Reset:** assert `rst` 3 cycles with pins idle -> all outputs at reset values; `tx_ready`=1.
- **Single byte:** load 0x5A, then master sends 0xAB at 1 MHz -> `rx_data`=0xAB with one `rx_valid` pulse; master reads 0x5A; `tx_ready` returns to 1 two cycles after the `ss` fall is sampled.
- **Back-to-back:** `ss` held low for 2 words; 0x12 loaded before the frame, 0x34 loaded on `tx_ready`; master sends 0xC3, 0x3C -> two `rx_valid` pulses with 0xC3 then 0x3C; master reads 0x12, 0x34; `tx_underrun` never pulses.
- **Underrun:** empty buffer, master sends 0x96 -> master reads 0x00; one `tx_underrun` pulse at frame start; `rx_data`=0x96.
- **Abort:** `ss` raised after 5 bits -> no `rx_valid`, `busy` falls; next full frame sending 0x81 -> `rx_data`=0x81.
- **Reset mid-frame:** `rst` pulsed with `ss` low and `sck` toggling -> `miso_oe`=0 and no `rx_valid` until `ss` goes high; next frame transfers 0xE7 correctly.
